// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds or subtracts two WIDTH-bit operands DIGIT bits per cycle, LSD first.
// Optional signed-overflow output Ovf is built only when DSA_OVF_EN is defined.
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             Abort,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid,
`ifdef DSA_OVF_EN
    output logic             Ovf,
`endif
    input  logic             out_ready
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = $clog2(NDIG) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [WIDTH-1:0] sa, sb, res, res_next;
    logic             carry, last;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    // one DIGIT-bit ripple add per cycle; the digit sum enters the result from the MSB end
    always_comb begin
        dsum     = {1'b0, sa[DIGIT-1:0]} + {1'b0, sb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        res_next = (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        last     = cnt == CW'(NDIG - 1);
    end
    // control FSM and datapath registers; Abort wins over every handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
`ifdef DSA_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else if (Abort) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= RUN;
                    sa    <= A;
                    sb    <= Sub ? ~B : B;
                    carry <= Sub | Cin;
                    cnt   <= '0;
                end
                RUN: begin
                    sa    <= sa >> DIGIT;
                    sb    <= sb >> DIGIT;
                    res   <= res_next;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                        Sum   <= res_next;
                        Cout  <= dsum[DIGIT];
`ifdef DSA_OVF_EN
                        // carry into the MSB recovered as a ^ b ^ sum of the top bit
                        Ovf   <= sa[DIGIT-1] ^ sb[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
`endif
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
